gpu_frame_loader: RTL and testbench
===================================

// Module: gpu_frame_loader
// PURPOSE
//  Host-side DMA stage for filterGPU. Sits between an 18-bit host word stream and the 3-lane data memory.
//  Packs host words into 3x18 vectors and writes them to memory while the GPU is held in reset.
//  Then releases the GPU and waits until its PC reaches HALT_PC, or until a timeout.
//  Finally reads memory back and streams the filtered vectors out, lane 0 first.
// PARAMETERS
//  NUM_VEC   1024     vectors loaded/dumped per frame (1..2**ADDR_W)
//  HALT_PC   32'd400  GPU PC value that signals the program has finished
//  TIMEOUT   2**20    max RUN cycles before a forced dump
// PORTS
//  CLK        in   1        single clock, rising edge
//  RST        in   1        asynchronous, active-high reset
//  start      in   1        1-cycle pulse; begins a frame when IDLE
//  in_data    in   18       host pixel word
//  in_valid   in   1        in_data valid
//  in_ready   out  1        loader accepts in_data this cycle
//  gpu_pc     in   32       filterGPU PC
//  gpu_rst    out  1        drives filterGPU RST; high except in RUN
//  mem_we     out  1        data memory write enable
//  mem_addr   out  10       data memory vector address
//  mem_wdata  out  3x18     vector write data, [2:0][17:0]
//  mem_rdata  in   3x18     vector read data; synchronous, valid 1 cycle after mem_addr
//  out_data   out  18       result word
//  out_valid  out  1        out_data valid
//  out_ready  in   1        sink accepts out_data
//  busy       out  1        high in any state other than IDLE
//  done       out  1        1-cycle pulse when the last word is accepted
//  timeout    out  1        sticky; set on forced dump, cleared by next start
// BEHAVIOUR
//  Reset: state=IDLE; gpu_rst=1; in_ready=0; mem_we=0; mem_addr=0; mem_wdata=0;
//   out_valid=0; out_data=0; busy=0; done=0; timeout=0. Lane/vector counters=0.
//  RST asserted mid-frame aborts immediately to the reset state. No partial write completes after RST.
//  FSM: IDLE -> LOAD -> RUN -> DUMP -> IDLE.
//  IDLE:
//   - start=1 -> LOAD; vec_cnt=0, lane_cnt=0, timeout cleared.
//   - start is ignored in all other states.
//  LOAD:
//   - in_ready=1. A word transfers on in_valid&in_ready and goes into lane[lane_cnt].
//   - On the 3rd word, mem_we=1 for exactly that next cycle, with mem_addr=vec_cnt and mem_wdata=packed vector.
//   - in_ready=0 during that write cycle. vec_cnt then increments.
//   - After the write of vector NUM_VEC-1 -> RUN.
//   - Gaps in in_valid stall; no word is lost or duplicated.
//  RUN:
//   - gpu_rst=0 and the cycle counter runs; the memory port is owned by the GPU, so mem_we=0.
//   - gpu_pc==HALT_PC -> DUMP.
//   - cycle counter reaching TIMEOUT-1 -> DUMP with timeout=1. HALT_PC wins if both occur in the same cycle.
//   - gpu_rst returns to 1 on the cycle the state leaves RUN.
//  DUMP:
//   - Issue mem_addr=vec_cnt (reset to 0 on entry). Capture mem_rdata one cycle later into the serializer.
//   - Emit lanes 0,1,2 with out_valid; advance only on out_valid&out_ready.
//   - out_data/out_valid are held stable while out_ready=0.
//   - The read of the next vector may be issued during lane 2 so there is no bubble when out_ready is held high.
//   - Steady-state throughput: 1 word/cycle.
//   - Last lane of vector NUM_VEC-1 accepted -> done pulse, go to IDLE.
//  Counters: vec_cnt is ADDR_W wide; NUM_VEC=2**ADDR_W terminates on a compare before wrap, never via overflow.
// STRUCTURE
//  - Shared package filter_pkg: LANE_W=18, LANES=3, ADDR_W=10, typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
//    state enum ldr_state_t {IDLE,LOAD,RUN,DUMP}.
//  - One sub-module, vec_serializer: vec_t in with load strobe, out to an 18-bit valid/ready stream,
//    lane counter, last-lane flag.
//  - Packing, FSM and counters stay in gpu_frame_loader.
// TESTING
//  1. Reset: RST=1 mid-LOAD after 4 words -> next cycle all outputs at reset values, gpu_rst=1, busy=0.
//  2. Load, NUM_VEC=4: start, then 12 words 1..12 with in_valid held -> 4 writes:
//     addr0={3,2,1} ... addr3={12,11,10}. In_ready low on each write cycle.
//  3. Run: model gpu_pc counting 0,4,8,... -> gpu_rst low until pc==HALT_PC,
//     then high next cycle; timeout=0.
//  4. Timeout: gpu_pc frozen at 0, TIMEOUT=16 -> DUMP entered after 16 RUN cycles, timeout=1.
//  5. Dump backpressure: memory preloaded, out_ready toggled 1010... -> out_data sequence matches
//     lane order exactly, no drops/dups, done pulses once after 12th word.
//  6. Spurious inputs: start pulsed during RUN and in_valid during DUMP -> no state change,
//     no mem writes, in_ready stays 0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and sizes for the filterGPU host loader: lane/vector geometry
// and the loader state encoding.
package filter_pkg;

    localparam int LANE_W     = 18;
    localparam int LANES      = 3;
    localparam int ADDR_W     = 10;
    localparam int LANE_CNT_W = 2;

    localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DUMP = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/gpu_frame_loader_if.sv
// Bundle of every loader signal except clock/reset. master = the loader,
// slave = the surrounding host, GPU, memory and sink.
// Handshakes: a word moves on a rising clock edge where valid and ready are
// both high; a valid source holds its data stable until that edge.
interface gpu_frame_loader_if;
    import filter_pkg::*;

    logic              start;
    logic [LANE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       gpu_pc;
    logic              gpu_rst;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    vec_t              mem_wdata;
    vec_t              mem_rdata;
    logic [LANE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              timeout;
    ldr_state_t        dbg_state;

    modport master (
        input  start, in_data, in_valid, gpu_pc, mem_rdata, out_ready,
        output in_ready, gpu_rst, mem_we, mem_addr, mem_wdata,
               out_data, out_valid, busy, done, timeout, dbg_state
    );

    modport slave (
        output start, in_data, in_valid, gpu_pc, mem_rdata, out_ready,
        input  in_ready, gpu_rst, mem_we, mem_addr, mem_wdata,
               out_data, out_valid, busy, done, timeout, dbg_state
    );

endinterface

// File: rtl/vec_serializer.sv
// Holds one 3-lane vector and streams it out lane 0 first over valid/ready.
// A load replaces the vector and restarts at lane 0; the caller loads only when free.
module vec_serializer
    import filter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  vec_t              vec_i,
    input  logic              out_ready_i,
    output logic [LANE_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              last_o,
    output logic              fire_o
);

    vec_t                  vec_q;
    logic [LANE_CNT_W-1:0] lane_q;
    logic                  valid_q;

    assign fire_o      = valid_q && out_ready_i;
    assign last_o      = (lane_q == LAST_LANE);
    assign out_valid_o = valid_q;
    assign out_data_o  = vec_q[lane_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q   <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            vec_q   <= vec_i;
            lane_q  <= '0;
            valid_q <= 1'b1;
        end else if (fire_o) begin
            if (last_o) begin
                valid_q <= 1'b0;
            end else begin
                lane_q <= lane_q + LANE_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpu_frame_loader.sv
// Host-side DMA stage for filterGPU: packs host words into vectors, runs the
// GPU until HALT_PC or timeout, then streams the memory contents back out.
module gpu_frame_loader
    import filter_pkg::*;
#(
    parameter int          NUM_VEC = 1024,
    parameter logic [31:0] HALT_PC = 32'd400,
    parameter int          TIMEOUT = 2**20
) (
    input logic                CLK,
    input logic                RST,
    gpu_frame_loader_if.master bus
);

    localparam int                CYC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_VEC = ADDR_W'(NUM_VEC - 1);

    ldr_state_t            state_q, state_d;
    logic [ADDR_W-1:0]     vec_cnt_q, vec_cnt_d;
    logic [LANE_CNT_W-1:0] lane_cnt_q, lane_cnt_d;
    vec_t                  ld_vec_q, ld_vec_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic                  timeout_q, timeout_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    vec_t                  mem_wdata_q, mem_wdata_d;
    logic                  req_q, req_d;
    logic                  rv_q, rv_d;
    logic                  rd_done_q, rd_done_d;
    logic                  pf_valid_q, pf_valid_d;
    vec_t                  pf_q, pf_d;
    logic                  done_q, done_d;

    logic              in_ready;
    logic              in_fire;
    logic              ser_load;
    logic              ser_fire;
    logic              ser_last;
    logic              ser_valid;
    logic              ser_free;
    logic [LANE_W-1:0] ser_data;

    // The write cycle owns the memory port, so no new word is taken then.
    assign in_ready = (state_q == LOAD) && !mem_we_q;
    assign in_fire  = in_ready && bus.in_valid;
    assign ser_free = !ser_valid || (ser_fire && ser_last);

    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        lane_cnt_d  = lane_cnt_q;
        ld_vec_d    = ld_vec_q;
        cyc_d       = cyc_q;
        timeout_d   = timeout_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        req_d       = 1'b0;
        rv_d        = req_q;
        rd_done_d   = rd_done_q;
        pf_valid_d  = pf_valid_q;
        pf_d        = pf_q;
        done_d      = 1'b0;
        ser_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    vec_cnt_d  = '0;
                    lane_cnt_d = '0;
                    timeout_d  = 1'b0;
                end
            end

            LOAD: begin
                if (mem_we_q) begin
                    if (vec_cnt_q == LAST_VEC) begin
                        state_d = RUN;
                        cyc_d   = '0;
                    end else begin
                        vec_cnt_d = vec_cnt_q + ADDR_W'(1);
                    end
                end else if (in_fire) begin
                    if (lane_cnt_q == LAST_LANE) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = vec_cnt_q;
                        mem_wdata_d = {bus.in_data, ld_vec_q[1], ld_vec_q[0]};
                        lane_cnt_d  = '0;
                    end else begin
                        ld_vec_d[lane_cnt_q] = bus.in_data;
                        lane_cnt_d           = lane_cnt_q + LANE_CNT_W'(1);
                    end
                end
            end

            RUN: begin
                // A halt in the same cycle as the timeout is a normal finish.
                if ((bus.gpu_pc == HALT_PC) || (cyc_q == LAST_CYC)) begin
                    state_d    = DUMP;
                    timeout_d  = (bus.gpu_pc != HALT_PC);
                    vec_cnt_d  = '0;
                    rd_done_d  = 1'b0;
                    pf_valid_d = 1'b0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            DUMP: begin
                ser_load = pf_valid_q && ser_free;
                if (rv_q) begin
                    pf_d       = bus.mem_rdata;
                    pf_valid_d = 1'b1;
                end else if (ser_load) begin
                    pf_valid_d = 1'b0;
                end
                // One read in flight; issuing as the prefetch drains keeps 1 word/cycle.
                if (!rd_done_q && !req_q && !rv_q && (!pf_valid_q || ser_load)) begin
                    mem_addr_d = vec_cnt_q;
                    req_d      = 1'b1;
                    if (vec_cnt_q == LAST_VEC) begin
                        rd_done_d = 1'b1;
                    end else begin
                        vec_cnt_d = vec_cnt_q + ADDR_W'(1);
                    end
                end
                if (ser_fire && ser_last && rd_done_q && !req_q && !rv_q && !pf_valid_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            lane_cnt_q  <= '0;
            ld_vec_q    <= '0;
            cyc_q       <= '0;
            timeout_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            req_q       <= 1'b0;
            rv_q        <= 1'b0;
            rd_done_q   <= 1'b0;
            pf_valid_q  <= 1'b0;
            pf_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            lane_cnt_q  <= lane_cnt_d;
            ld_vec_q    <= ld_vec_d;
            cyc_q       <= cyc_d;
            timeout_q   <= timeout_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            req_q       <= req_d;
            rv_q        <= rv_d;
            rd_done_q   <= rd_done_d;
            pf_valid_q  <= pf_valid_d;
            pf_q        <= pf_d;
            done_q      <= done_d;
        end
    end

    vec_serializer u_ser (
        .clk         (CLK),
        .rst         (RST),
        .load_i      (ser_load),
        .vec_i       (pf_q),
        .out_ready_i (bus.out_ready),
        .out_data_o  (ser_data),
        .out_valid_o (ser_valid),
        .last_o      (ser_last),
        .fire_o      (ser_fire)
    );

    assign bus.in_ready  = in_ready;
    assign bus.gpu_rst   = (state_q != RUN);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.out_data  = ser_data;
    assign bus.out_valid = ser_valid;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_gpu_frame_loader.sv
// Directed bench for gpu_frame_loader with NUM_VEC=4, HALT_PC=40, TIMEOUT=16,
// a behavioural synchronous memory and a PC-counting GPU model.
module tb_gpu_frame_loader;
    import filter_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    gpu_frame_loader_if bus();

    gpu_frame_loader #(
        .NUM_VEC (4),
        .HALT_PC (32'd40),
        .TIMEOUT (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    vec_t        mem [0:1023];
    logic        pc_freeze;
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [63:0] wr_q[$];
    logic [17:0] exp_q[$];

    // Memory and GPU models: read data appears the cycle after the address.
    always @(posedge CLK) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.gpu_rst) bus.gpu_pc <= 32'd0;
        else if (!pc_freeze) bus.gpu_pc <= bus.gpu_pc + 32'd4;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.mem_we) begin
            wr_q.push_back({bus.mem_addr, bus.mem_wdata});
            check_eq("in_ready_on_write", 64'(bus.in_ready), 64'd0);
        end
        if (bus.done) done_cnt++;
    end

    task automatic check_reset(input string tag);
        check_eq({tag, "_gpu_rst"},   64'(bus.gpu_rst),   64'd1);
        check_eq({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check_eq({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        check_eq({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        check_eq({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_out_data"},  64'(bus.out_data),  64'd0);
        check_eq({tag, "_busy"},      64'(bus.busy),      64'd0);
        check_eq({tag, "_done"},      64'(bus.done),      64'd0);
        check_eq({tag, "_timeout"},   64'(bus.timeout),   64'd0);
        check_eq({tag, "_state"},     64'(bus.dbg_state), 64'(IDLE));
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic push_word(input logic [17:0] d);
        int g = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 20) begin
            @(negedge CLK);
            g++;
        end
        check_eq("in_ready_wait", 64'(g < 20), 64'd1);
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles with gpu_rst low; pulses start inside RUN to prove it is ignored.
    task automatic count_run(output int n);
        int g = 0;
        n = 0;
        while (bus.gpu_rst && g < 100) begin
            @(negedge CLK);
            g++;
        end
        check_eq("run_entry_wait", 64'(g < 100), 64'd1);
        while (!bus.gpu_rst && n < 100) begin
            if (n == 2) bus.start = 1'b1;
            if (n == 3) begin
                bus.start = 1'b0;
                check_eq("start_in_run", 64'(bus.dbg_state), 64'(RUN));
            end
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic dump_collect(input bit toggle, output int first_cyc, output int last_cyc);
        int          cyc = 0;
        int          got = 0;
        bit          tog = 1'b0;
        logic        held_v = 1'b0;
        logic [17:0] held_d = '0;
        logic [17:0] e;
        first_cyc    = -1;
        last_cyc     = -1;
        done_cnt     = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 18'h3ffff;
        while (got < 12 && cyc < 300) begin
            bus.out_ready = toggle ? tog : 1'b1;
            tog = !tog;
            check_eq("in_ready_dump", 64'(bus.in_ready), 64'd0);
            if (held_v) check_eq("hold_stable", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, held_d}));
            if (bus.out_valid && bus.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
                check_eq("dump_word", 64'(bus.out_data), 64'(e));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            @(negedge CLK);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("dump_count", 64'(got), 64'd12);
        check_eq("done_after_last", 64'(bus.done), 64'd1);
        check_eq("idle_after_dump", 64'(bus.dbg_state), 64'(IDLE));
        @(negedge CLK);
        check_eq("done_one_pulse", 64'(done_cnt), 64'd1);
        check_eq("dump_no_writes", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        int          n;
        int          f;
        int          l;
        vec_t        v;
        logic [63:0] e;
        bus.start     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        pc_freeze     = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(negedge CLK);
        check_reset("por");
        RST = 1'b0;
        @(negedge CLK);

        // Abort mid-LOAD after four words.
        pulse_start();
        for (int i = 1; i <= 4; i++) push_word(18'(i));
        #2 RST = 1'b1;
        #1 check_reset("rst_async");
        @(negedge CLK);
        check_reset("rst_hold");
        check_eq("rst_write_count", 64'(wr_q.size()), 64'd1);
        wr_q.delete();
        RST = 1'b0;
        @(negedge CLK);

        // Frame 1: load 1..12, GPU halts at pc 40, dump with 1010 backpressure.
        pulse_start();
        check_eq("load_busy", 64'(bus.busy), 64'd1);
        for (int i = 1; i <= 12; i++) push_word(18'(i));
        count_run(n);
        check_eq("run_cycles_halt", 64'(n), 64'd11);
        check_eq("halt_no_timeout", 64'(bus.timeout), 64'd0);
        check_eq("halt_to_dump", 64'(bus.dbg_state), 64'(DUMP));
        check_eq("write_count", 64'(wr_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            v[0] = 18'(3 * k + 1);
            v[1] = 18'(3 * k + 2);
            v[2] = 18'(3 * k + 3);
            e = {10'(k), v};
            check_eq("write_vec", (k < wr_q.size()) ? wr_q[k] : 64'h0, e);
        end
        wr_q.delete();
        for (int i = 1; i <= 12; i++) exp_q.push_back(18'(i));
        dump_collect(1'b1, f, l);

        // Frame 2: load 13..24, PC frozen so the run times out; dump at full rate.
        pc_freeze = 1'b1;
        pulse_start();
        for (int i = 13; i <= 24; i++) push_word(18'(i));
        count_run(n);
        check_eq("run_cycles_timeout", 64'(n), 64'd16);
        check_eq("timeout_set", 64'(bus.timeout), 64'd1);
        check_eq("timeout_to_dump", 64'(bus.dbg_state), 64'(DUMP));
        check_eq("write_count_2", 64'(wr_q.size()), 64'd4);
        wr_q.delete();
        for (int i = 13; i <= 24; i++) exp_q.push_back(18'(i));
        dump_collect(1'b0, f, l);
        check_eq("full_rate_span", 64'(l - f), 64'd11);

        // Sticky timeout survives IDLE and clears on the next start.
        check_eq("timeout_sticky", 64'(bus.timeout), 64'd1);
        pulse_start();
        check_eq("timeout_cleared", 64'(bus.timeout), 64'd0);
        check_eq("restart_load", 64'(bus.dbg_state), 64'(LOAD));
        RST = 1'b1;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
